// File: rtl/channel_sample_pack.sv
// channel_sample_pack: synchronise H/L comparator channels, decimate, pack PACK samples per word with valid/ready and sticky overflow
module channel_sample_pack #(
    parameter int NUM_CH = 5,
    parameter int SYNC   = 2,
    parameter int PACK   = 4,
    parameter int DIV_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          CH_H,
    input  logic [NUM_CH-1:0]          CH_L,
    input  logic                       en,
    input  logic [DIV_W-1:0]           decimator,
    output logic [2*NUM_CH*PACK-1:0]   smpl,
    output logic                       smpl_vld,
    input  logic                       smpl_rdy,
    output logic                       ovfl,
    input  logic                       ovfl_clr,
    output logic [NUM_CH-1:0]          CH_Hsmpl,
    output logic [NUM_CH-1:0]          CH_Lsmpl
);
    localparam int S  = 2*NUM_CH;
    localparam int W  = S*PACK;
    localparam int PW = PACK > 1 ? $clog2(PACK) : 1;
    logic [SYNC-1:0][NUM_CH-1:0] sh, sl;
    logic [DIV_W-1:0] cnt;
    logic [PW-1:0] pcnt;
    logic [W-1:0] pack_sr, nxt;
    logic [S-1:0] slot;
    logic tick, done;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        assign slot[2*i+1] = sh[SYNC-1][i];
        assign slot[2*i]   = sl[SYNC-1][i];
    end
    if (PACK > 1) begin : g_shift
        assign nxt = {slot, pack_sr[W-1:S]};
    end else begin : g_single
        assign nxt = slot;
    end
    assign tick = en && cnt >= decimator;
    assign done = tick && pcnt == PW'(PACK-1);
    always_ff @(posedge clk) begin
        if (rst) begin
            sh       <= '0;
            sl       <= '0;
            cnt      <= '0;
            pcnt     <= '0;
            pack_sr  <= '0;
            smpl     <= '0;
            smpl_vld <= 1'b0;
            ovfl     <= 1'b0;
            CH_Hsmpl <= '0;
            CH_Lsmpl <= '0;
        end else begin
            sh   <= {sh[SYNC-2:0], CH_H};
            sl   <= {sl[SYNC-2:0], CH_L};
            cnt  <= (tick || !en) ? '0 : cnt + DIV_W'(1);
            pcnt <= (!en || done) ? '0 : pcnt + PW'(tick);
            if (tick) begin
                pack_sr  <= nxt;
                CH_Hsmpl <= sh[SYNC-1];
                CH_Lsmpl <= sl[SYNC-1];
            end
            if (done)
                smpl <= nxt;
            smpl_vld <= done || (smpl_vld && !smpl_rdy);
            ovfl     <= (done && smpl_vld && !smpl_rdy) || (ovfl && !ovfl_clr);
        end
    end
endmodule

// File: tb/tb_channel_sample_pack.sv
// tb_channel_sample_pack: randomized and directed stimulus against a queue-based reference model with a scoreboard monitor
module tb_channel_sample_pack;
    localparam int NUM_CH = 5;
    localparam int SYNC   = 2;
    localparam int PACK   = 4;
    localparam int DIV_W  = 8;
    localparam int S      = 2*NUM_CH;
    localparam int W      = S*PACK;

    logic clk = 0, rst = 1, en = 0, smpl_rdy = 0, ovfl_clr = 0;
    logic [NUM_CH-1:0] CH_H = '0, CH_L = '0, CH_Hsmpl, CH_Lsmpl;
    logic [DIV_W-1:0] decimator = '0;
    logic [W-1:0] smpl;
    logic smpl_vld, ovfl;

    always #5 clk = ~clk;

    channel_sample_pack #(.NUM_CH(NUM_CH), .SYNC(SYNC), .PACK(PACK), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .CH_H(CH_H), .CH_L(CH_L), .en(en), .decimator(decimator),
        .smpl(smpl), .smpl_vld(smpl_vld), .smpl_rdy(smpl_rdy), .ovfl(ovfl), .ovfl_clr(ovfl_clr),
        .CH_Hsmpl(CH_Hsmpl), .CH_Lsmpl(CH_Lsmpl)
    );

    int n_vec = 0, n_err = 0;

    logic [2*NUM_CH-1:0] hq[$];
    logic [S-1:0] parts[$];
    logic [W-1:0] sb[$];
    int since = 0;
    logic m_vld = 0, m_ovfl = 0;
    logic [NUM_CH-1:0] m_h = '0, m_l = '0;
    logic [W-1:0] m_smpl = '0;

    function automatic logic [S-1:0] mk_slot(input logic [NUM_CH-1:0] h, input logic [NUM_CH-1:0] l);
        logic [S-1:0] s;
        for (int i = 0; i < NUM_CH; i++) begin
            s[2*i+1] = h[i];
            s[2*i]   = l[i];
        end
        return s;
    endfunction

    // Reference model: inputs seen SYNC edges late, one slot per qualifying enabled cycle, PACK slots per word
    always @(posedge clk) begin : model
        logic [2*NUM_CH-1:0] syn;
        logic tk, dn;
        logic [W-1:0] wd;
        if (rst) begin
            hq.delete();
            repeat (SYNC) hq.push_back('0);
            parts.delete();
            sb.delete();
            since = 0;
            m_vld = 0;
            m_ovfl = 0;
            m_h = '0;
            m_l = '0;
            m_smpl = '0;
        end else begin
            syn = hq.pop_front();
            hq.push_back({CH_H, CH_L});
            tk = en && since >= int'(decimator);
            since = (tk || !en) ? 0 : since + 1;
            dn = 0;
            wd = '0;
            if (!en)
                parts.delete();
            if (tk) begin
                m_h = syn[2*NUM_CH-1:NUM_CH];
                m_l = syn[NUM_CH-1:0];
                parts.push_back(mk_slot(m_h, m_l));
                if (parts.size() == PACK) begin
                    for (int i = 0; i < PACK; i++)
                        wd = wd | (W'(parts[i]) << (S*i));
                    parts.delete();
                    dn = 1;
                end
            end
            if (dn) begin
                if (m_vld && !smpl_rdy && sb.size() > 0)
                    void'(sb.pop_back());
                sb.push_back(wd);
                m_smpl = wd;
            end
            m_ovfl = (dn && m_vld && !smpl_rdy) || (m_ovfl && !ovfl_clr);
            m_vld = dn || (m_vld && !smpl_rdy);
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        chk("smpl_vld", W'(smpl_vld), W'(m_vld));
        chk("ovfl", W'(ovfl), W'(m_ovfl));
        chk("CH_Hsmpl", W'(CH_Hsmpl), W'(m_h));
        chk("CH_Lsmpl", W'(CH_Lsmpl), W'(m_l));
        chk("smpl_hold", smpl, m_smpl);
        if (smpl_vld && smpl_rdy) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL xfer_word at %0t: got %h expected no word pending", $time, smpl);
            end else
                chk("xfer_word", smpl, sb.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(3);
        rst = 0;
        decimator = 0; CH_H = '1; CH_L = '0; smpl_rdy = 1; en = 1;
        cyc(40);
        decimator = 3;
        cyc(80);
        en = 0; cyc(1); en = 1; cyc(3);
        decimator = 1;
        cyc(30);
        en = 0; decimator = 3; CH_H = '0; CH_L = 5'h01; cyc(4);
        en = 1; cyc(4);
        CH_L = '0; cyc(12);
        cyc(12);
        CH_H = 5'h10; cyc(3);
        CH_H = '0; cyc(10);
        decimator = 0; smpl_rdy = 0; cyc(12);
        smpl_rdy = 1; cyc(1);
        smpl_rdy = 0; en = 0; cyc(2);
        ovfl_clr = 1; cyc(1);
        ovfl_clr = 0; en = 1; cyc(10);
        ovfl_clr = 1; cyc(8);
        ovfl_clr = 0; smpl_rdy = 1; cyc(5);
        decimator = 1; en = 0; cyc(1);
        en = 1; CH_H = 5'h15; CH_L = 5'h0A; cyc(4);
        en = 0; CH_H = 5'h03; CH_L = 5'h1C; cyc(3);
        en = 1; cyc(20);
        decimator = 0; cyc(6);
        rst = 1; cyc(2);
        rst = 0; cyc(10);
        for (int k = 0; k < 3000; k++) begin
            CH_H = NUM_CH'($urandom);
            CH_L = NUM_CH'($urandom);
            smpl_rdy = $urandom_range(0, 3) != 0;
            ovfl_clr = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 99) == 0) en = !en;
            if ($urandom_range(0, 199) == 0) decimator = DIV_W'($urandom_range(0, 3));
            rst = $urandom_range(0, 999) == 0;
            cyc(1);
        end
        rst = 0;
        cyc(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
